// File: rtl/l2_request_arbiter_if.sv
// rtl/l2_request_arbiter_if.sv - L1 cache / write-back / L2 port signal bundle for the request arbiter
interface l2_request_arbiter_if #(
  parameter int N = 32
);
  logic         ic_req_valid;
  logic [N-1:0] ic_req_addr;
  logic         ic_done;
  logic         dc_req_valid;
  logic         dc_req_rfo;
  logic [N-1:0] dc_req_addr;
  logic         dc_done;
  logic         wb_valid;
  logic [N-1:0] wb_addr;
  logic         wb_ready;
  logic         l2_req_valid;
  logic         l2_req_ready;
  logic [1:0]   l2_req_cmd;
  logic [N-1:0] l2_req_addr;
  logic         l2_resp_valid;
  logic [31:0]  rd_grant_count;
  logic [31:0]  wb_drain_count;
  logic [31:0]  hazard_stall_count;

  modport master (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rfo, dc_req_addr,
    input  wb_valid, wb_addr, l2_req_ready, l2_resp_valid,
    output ic_done, dc_done, wb_ready, l2_req_valid, l2_req_cmd, l2_req_addr,
    output rd_grant_count, wb_drain_count, hazard_stall_count
  );

  modport slave (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rfo, dc_req_addr,
    output wb_valid, wb_addr, l2_req_ready, l2_resp_valid,
    input  ic_done, dc_done, wb_ready, l2_req_valid, l2_req_cmd, l2_req_addr,
    input  rd_grant_count, wb_drain_count, hazard_stall_count
  );
endinterface

// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - shares the L2 port between I-cache reads, D-cache reads and a write-back FIFO
module l2_request_arbiter #(
  parameter int N             = 32,
  parameter int CacheLineSize = 64,
  parameter int WB_DEPTH      = 4
) (
  input logic clock,
  input logic reset,
  l2_request_arbiter_if.master bus
);
  localparam int OFFSET = $clog2(CacheLineSize);
  localparam int LW     = N - OFFSET;
  localparam int PW     = $clog2(WB_DEPTH);
  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_RFO   = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t        state;
  logic [LW-1:0] wb_line [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          last_ic;
  logic          owner_dc;
  logic          req_valid_q;
  logic [1:0]    cmd_q;
  logic [LW-1:0] line_q;
  logic [31:0]   rd_cnt, wb_cnt, hz_cnt;

  logic          wb_full, wb_empty, enq, deq;
  logic          cand, pick_dc, buf_hit, enq_hit;
  logic [LW-1:0] cand_line, enq_line;
  logic          take_wb, take_rd, hazard, resp_fire;
  logic          unused_low;

  assign wb_full   = (count == (PW+1)'(WB_DEPTH));
  assign wb_empty  = (count == '0);
  assign enq       = bus.wb_valid && !wb_full;
  assign deq       = (state == ISSUE) && bus.l2_req_ready && (cmd_q == CMD_WRITE);
  assign enq_line  = bus.wb_addr[N-1:OFFSET];
  assign unused_low = ^{bus.wb_addr[OFFSET-1:0], bus.ic_req_addr[OFFSET-1:0],
                        bus.dc_req_addr[OFFSET-1:0]};

  // last_ic set means the D-cache wins the next tie
  assign cand      = bus.ic_req_valid || bus.dc_req_valid;
  assign pick_dc   = bus.dc_req_valid && (!bus.ic_req_valid || last_ic);
  assign cand_line = pick_dc ? bus.dc_req_addr[N-1:OFFSET] : bus.ic_req_addr[N-1:OFFSET];
  assign enq_hit   = enq && (enq_line == cand_line);

  always_comb begin
    buf_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (wb_line[head + PW'(i)] == cand_line)) buf_hit = 1'b1;
    end
  end

  always_comb begin
    take_wb = 1'b0;
    take_rd = 1'b0;
    hazard  = 1'b0;
    if (state == IDLE) begin
      if (wb_full) begin
        take_wb = 1'b1;
      end else if (cand && (buf_hit || enq_hit)) begin
        hazard  = 1'b1;
        take_wb = buf_hit;
      end else if (cand) begin
        take_rd = 1'b1;
      end else if (!wb_empty) begin
        take_wb = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      last_ic     <= 1'b1;
      owner_dc    <= 1'b0;
      req_valid_q <= 1'b0;
      cmd_q       <= CMD_READ;
      line_q      <= '0;
      rd_cnt      <= '0;
      wb_cnt      <= '0;
      hz_cnt      <= '0;
    end else begin
      if (enq) begin
        wb_line[tail] <= enq_line;
        tail          <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;

      if (hazard) hz_cnt <= hz_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (take_wb) begin
            cmd_q       <= CMD_WRITE;
            line_q      <= wb_line[head];
            req_valid_q <= 1'b1;
            state       <= ISSUE;
          end else if (take_rd) begin
            cmd_q       <= (pick_dc && bus.dc_req_rfo) ? CMD_RFO : CMD_READ;
            line_q      <= cand_line;
            owner_dc    <= pick_dc;
            last_ic     <= !pick_dc;
            rd_cnt      <= rd_cnt + 32'd1;
            req_valid_q <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.l2_req_ready) begin
            req_valid_q <= 1'b0;
            if (cmd_q == CMD_WRITE) begin
              wb_cnt <= wb_cnt + 32'd1;
              state  <= IDLE;
            end else begin
              state  <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (bus.l2_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing on the response cycle must not leak a done pulse
  assign resp_fire = (state == WAIT_RESP) && bus.l2_resp_valid && !reset;

  assign bus.ic_done            = resp_fire && !owner_dc;
  assign bus.dc_done            = resp_fire && owner_dc;
  assign bus.wb_ready           = !wb_full;
  assign bus.l2_req_valid       = req_valid_q;
  assign bus.l2_req_cmd         = cmd_q;
  assign bus.l2_req_addr        = {line_q, {OFFSET{1'b0}}};
  assign bus.rd_grant_count     = rd_cnt;
  assign bus.wb_drain_count     = wb_cnt;
  assign bus.hazard_stall_count = hz_cnt;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb/tb_l2_request_arbiter.sv - randomized bench for l2_request_arbiter against a queue-based reference model
module tb_l2_request_arbiter;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  l2_request_arbiter_if #(.N(32)) bus ();

  l2_request_arbiter #(.N(32), .CacheLineSize(64), .WB_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mq[$];
  int          phase;
  bit          m_last_dc, m_owner_dc, m_fresh;
  logic [1:0]  m_cmd;
  logic [31:0] m_addr;
  int unsigned m_rd, m_wb, m_hz;
  bit          exp_ic_done, exp_dc_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    phase      = 0;
    m_last_dc  = 1'b0;
    m_owner_dc = 1'b0;
    m_fresh    = 1'b1;
    m_cmd      = 2'd0;
    m_addr     = 32'd0;
    m_rd = 0; m_wb = 0; m_hz = 0;
  endtask

  task automatic load_wb();
    m_cmd   = 2'd2;
    m_addr  = mq[0];
    phase   = 1;
    m_fresh = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0000_1000 + ($urandom_range(0, 5) << 6) + $urandom_range(0, 63);
  endfunction

  // One clock: compare the DUT against the model, advance the model, land at posedge+1
  task automatic step();
    bit pick_dc, cand, enq, qhit, ehit;
    logic [31:0] cline;
    @(negedge clock);
    exp_ic_done = !reset && phase == 2 && bus.l2_resp_valid && !m_owner_dc;
    exp_dc_done = !reset && phase == 2 && bus.l2_resp_valid && m_owner_dc;
    check_eq("l2_req_valid", bus.l2_req_valid, 32'(phase == 1));
    if (phase == 1 || m_fresh) begin
      check_eq("l2_req_cmd", bus.l2_req_cmd, m_cmd);
      check_eq("l2_req_addr", bus.l2_req_addr, m_addr);
    end
    check_eq("ic_done", bus.ic_done, exp_ic_done);
    check_eq("dc_done", bus.dc_done, exp_dc_done);
    check_eq("wb_ready", bus.wb_ready, 32'(mq.size() != 4));
    check_eq("rd_grant_count", bus.rd_grant_count, m_rd);
    check_eq("wb_drain_count", bus.wb_drain_count, m_wb);
    check_eq("hazard_stall_count", bus.hazard_stall_count, m_hz);

    if (reset) begin
      model_reset();
    end else begin
      enq = bus.wb_valid && mq.size() < 4;
      case (phase)
        0: begin
          cand    = bus.ic_req_valid || bus.dc_req_valid;
          pick_dc = bus.dc_req_valid && (!bus.ic_req_valid || !m_last_dc);
          cline   = (pick_dc ? bus.dc_req_addr : bus.ic_req_addr) & LINE_MASK;
          qhit    = 1'b0;
          foreach (mq[i]) if (mq[i] == cline) qhit = 1'b1;
          ehit    = enq && ((bus.wb_addr & LINE_MASK) == cline);
          if (mq.size() == 4) load_wb();
          else if (cand && (qhit || ehit)) begin
            m_hz++;
            if (qhit) load_wb();
          end else if (cand) begin
            m_rd++;
            m_last_dc  = pick_dc;
            m_owner_dc = pick_dc;
            m_cmd      = (pick_dc && bus.dc_req_rfo) ? 2'd1 : 2'd0;
            m_addr     = cline;
            phase      = 1;
            m_fresh    = 1'b0;
          end else if (mq.size() > 0) load_wb();
        end
        1: if (bus.l2_req_ready) begin
          if (m_cmd == 2'd2) begin
            void'(mq.pop_front());
            m_wb++;
            phase = 0;
          end else begin
            phase = 2;
          end
        end
        default: if (bus.l2_resp_valid) phase = 0;
      endcase
      if (enq) mq.push_back(bus.wb_addr & LINE_MASK);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_random();
    if (exp_ic_done) bus.ic_req_valid = 1'b0;
    else if (!bus.ic_req_valid && $urandom_range(0, 3) == 0) begin
      bus.ic_req_valid = 1'b1;
      bus.ic_req_addr  = rand_addr();
    end
    if (exp_dc_done) bus.dc_req_valid = 1'b0;
    else if (!bus.dc_req_valid && $urandom_range(0, 3) == 0) begin
      bus.dc_req_valid = 1'b1;
      bus.dc_req_rfo   = 1'($urandom_range(0, 1));
      bus.dc_req_addr  = rand_addr();
    end
    bus.wb_valid      = ($urandom_range(0, 2) == 0);
    bus.wb_addr       = rand_addr();
    bus.l2_req_ready  = ($urandom_range(0, 3) != 0);
    bus.l2_resp_valid = ($urandom_range(0, 2) != 0);
    reset             = ($urandom_range(0, 249) == 0);
  endtask

  initial begin
    bus.ic_req_valid = 0; bus.ic_req_addr = 0;
    bus.dc_req_valid = 0; bus.dc_req_rfo = 0; bus.dc_req_addr = 0;
    bus.wb_valid = 0; bus.wb_addr = 0;
    bus.l2_req_ready = 0; bus.l2_resp_valid = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // Uncontended read: issue in cycle 1, done in cycle 2
    bus.ic_req_valid  = 1'b1;
    bus.ic_req_addr   = 32'h1234_5678;
    bus.l2_req_ready  = 1'b1;
    bus.l2_resp_valid = 1'b1;
    step();
    check_eq("single_valid", bus.l2_req_valid, 32'd1);
    check_eq("single_cmd", bus.l2_req_cmd, 32'd0);
    check_eq("single_addr", bus.l2_req_addr, 32'h1234_5640);
    step();
    check_eq("single_done", bus.ic_done, 32'd1);
    step();
    bus.ic_req_valid = 1'b0;
    check_eq("single_grants", bus.rd_grant_count, 32'd1);

    // Writeback and read to the same line arriving together
    bus.l2_resp_valid = 1'b0;
    bus.wb_valid      = 1'b1;
    bus.wb_addr       = 32'h0000_4000;
    bus.dc_req_valid  = 1'b1;
    bus.dc_req_rfo    = 1'b0;
    bus.dc_req_addr   = 32'h0000_4004;
    step();
    bus.wb_valid = 1'b0;
    check_eq("same_cycle_hold", bus.l2_req_valid, 32'd0);
    step();
    check_eq("same_cycle_wr_cmd", bus.l2_req_cmd, 32'd2);
    check_eq("same_cycle_wr_addr", bus.l2_req_addr, 32'h0000_4000);
    step();
    step();
    check_eq("same_cycle_rd_cmd", bus.l2_req_cmd, 32'd0);
    check_eq("same_cycle_rd_addr", bus.l2_req_addr, 32'h0000_4000);
    bus.l2_resp_valid = 1'b1;
    step();
    check_eq("same_cycle_done", bus.dc_done, 32'd1);
    check_eq("same_cycle_hazards", bus.hazard_stall_count, 32'd2);
    step();
    if (exp_dc_done) bus.dc_req_valid = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Shares the single L1-to-L2 bus among three requesters: instruction-cache read misses, data-cache read/RFO misses, and data-cache dirty-line writebacks.
- Writebacks are held in a small FIFO write-back buffer.
- Reads are arbitrated round-robin between the I-cache and the D-cache.
- A read whose line matches a buffered writeback forces that writeback to drain first.
- The block sits between the L1 instruction cache, the L1 data cache and the L2 port model. It keeps one L2 transaction outstanding at a time.

Parameters:
- N, 32, address width.
- CacheLineSize, 64, line size in bytes. OFFSET = $clog2(CacheLineSize).
- WB_DEPTH, 4, write-back buffer entries (power of two, at least 2).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ic_req_valid  in  1  I-cache read miss pending. Held until ic_done.
- ic_req_addr  in  N  I-cache miss address. Stable while valid.
- ic_done  out  1  one-cycle pulse: I-cache line returned.
- dc_req_valid  in  1  D-cache miss pending. Held until dc_done.
- dc_req_rfo  in  1  1 = read-for-ownership, 0 = read.
- dc_req_addr  in  N  D-cache miss address.
- dc_done  out  1  one-cycle pulse: D-cache line returned.
- wb_valid  in  1  dirty line to write back.
- wb_addr  in  N  writeback address.
- wb_ready  out  1  buffer can accept an entry.
- l2_req_valid  out  1  L2 command valid.
- l2_req_ready  in  1  L2 accepts the command.
- l2_req_cmd  out  2  0 = READ, 1 = RFO, 2 = WRITE.
- l2_req_addr  out  N  line-aligned address (low OFFSET bits are 0).
- l2_resp_valid  in  1  read data returned.
- rd_grant_count  out  32  reads issued to L2 (wraps).
- wb_drain_count  out  32  writebacks issued (wraps).
- hazard_stall_count  out  32  cycles in IDLE deferred by a line-match hazard (wraps).

Behaviour:
- Line compare uses addr[N-1:OFFSET] only.
- Reset:
  - State goes to IDLE and the buffer empties (count = 0, pointers = 0).
  - Buffered writebacks are discarded.
  - The round-robin pointer is set so the D-cache wins the first tie.
  - All counters are 0.
  - From the cycle after reset, all outputs are 0 except wb_ready = 1.
  - Reset mid-transaction aborts it. No done pulse is produced.
- WB buffer:
  - wb_ready = (count != WB_DEPTH), from registered count. There is no full-bypass.
  - Enqueue when wb_valid && wb_ready.
  - Dequeue when a WRITE handshakes.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Pointers wrap modulo WB_DEPTH.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE: evaluated each cycle; first matching rule wins.
  1. Buffer full: load head as WRITE and go to ISSUE.
  2. Read candidate exists and its line matches any valid buffered entry, or the wb entry being enqueued this cycle: load head as WRITE, go to ISSUE, and increment hazard_stall_count. If the only match is the same-cycle enqueue, stay in IDLE instead (still increment the count).
  3. Read candidate exists: load it as READ or RFO, record the owner, update the round-robin pointer, increment rd_grant_count, and go to ISSUE.
  4. Buffer not empty: load head as WRITE and go to ISSUE.
  5. Otherwise stay in IDLE.
- Read candidate selection:
  - If both requesters are valid, pick the one not granted last.
  - If only one is valid, pick it.
  - I-cache requests are always READ. D-cache requests use cmd = dc_req_rfo ? RFO : READ.
- ISSUE:
  - l2_req_valid = 1. cmd and addr are registered and stable until l2_req_ready.
  - On handshake for WRITE: pop the buffer, increment wb_drain_count, return to IDLE.
  - On handshake for READ or RFO: go to WAIT_RESP.
- WAIT_RESP:
  - l2_req_valid = 0.
  - On l2_resp_valid, the owner's done = 1 combinationally in that cycle, then go to IDLE.
  - The requester drops valid on the next edge, so no re-grant occurs.
  - l2_resp_valid is ignored in IDLE and ISSUE.
- Latency: an uncontended read asserted in cycle 0 presents l2_req_valid in cycle 1. If ready = 1 in cycle 1 and resp = 1 in cycle 2, done pulses in cycle 2.
- Writebacks enqueued while a transaction is in flight wait in the buffer. The buffer never reorders.

Test Plan:
- Single read: reset, then ic_req_valid with addr 0x1234_5678 and ready/resp held at 1 → cycle 1 shows l2_req_valid, cmd 0, addr 0x1234_5640; ic_done in cycle 2; rd_grant_count = 1.
- Round-robin: I and D valid together for two consecutive grants (D addr 0x0000_0080, rfo = 1) → D is issued first as cmd 1, then I as cmd 0; done pulses in that order.
- Full buffer priority: enqueue 4 WBs (0x100, 0x140, 0x180, 0x1C0) while l2_req_ready = 0, then raise ic_req_valid → wb_ready = 0 after the 4th. The first issue is WRITE 0x100 ahead of the read.
- Hazard: buffer holds WB 0x0000_2000 and 0x0000_3000; dc reads 0x0000_3010 → WRITE 0x2000, then WRITE 0x3000, then READ 0x3000; hazard_stall_count = 2.
- Same-cycle hazard: wb_valid 0x4000 and dc_req 0x4004 in the same cycle, buffer empty → IDLE holds 1 cycle, then WRITE 0x4000, then READ 0x4000.
- Reset mid-op: assert reset while in WAIT_RESP with 2 buffered WBs → next cycle l2_req_valid = 0, no done pulse, wb_ready = 1, all counters 0.
